// File: rtl/spi_fpmul_pkg.sv
// Shared types and constants for the SPI front end of the bfloat16 multiplier.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package spi_fpmul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int FRAME_BITS = 32;

    localparam int ST_VALID = 15;
    localparam int ST_BUSY  = 14;
    localparam int ST_OVR   = 13;
    localparam int ST_LEN   = 12;
    localparam int ST_TMO   = 11;

endpackage

// File: rtl/spi_fpmul_frontend_sync.sv
// Two-flop synchroniser with rise/fall pulses for one asynchronous SPI pin.
// Latency: pulses appear combinationally two clk after the pin changes.
// Backpressure: none; every synchronised transition yields one pulse.
module spi_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    // [0],[1] form the synchroniser, [2] holds the previous synced value.
    // Reset low so a pin already low at reset release produces no fall.
    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh <= '0;
        end else begin
            sh <= {sh[1:0], d};
        end
    end

    assign rise = sh[1] & ~sh[2];
    assign fall = ~sh[1] & sh[2];

endmodule

// File: rtl/spi_fpmul_frontend.sv
// SPI slave that loads two operands, starts fpmul and returns {result, status}.
// Latency: cs_n pin rise to en is 4 clk; ready to y_reg/valid is 1 clk.
// Backpressure: frames arriving while busy are dropped and flagged as overrun.
module spi_fpmul_frontend
    import spi_fpmul_pkg::*;
#(
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          cs_n,
    input  logic          mosi,
    output logic          miso,
    output logic [DW-1:0] x1,
    output logic [DW-1:0] x2,
    output logic          en,
    input  logic [DW-1:0] y,
    input  logic          ready
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;
    logic [1:0] mosi_sync;

    spi_sync u_sclk_sync (.clk(clk), .rst(rst), .d(sclk), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync u_cs_sync   (.clk(clk), .rst(rst), .d(cs_n), .rise(cs_rise),   .fall(cs_fall));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_sync <= '0;
        end else begin
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    logic                  armed;
    logic                  fend;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] rx;
    logic [FRAME_BITS-1:0] tx;
    logic [DW-1:0]         y_reg;
    logic [TW-1:0]         tmo_cnt;
    logic                  valid, overrun, len_err, tmo;
    logic [15:0]           status;
    state_t                state, state_nxt;

    logic full_len, accept, tmo_hit;
    logic set_valid, set_tmo, set_len, set_ovr;

    assign full_len  = (bit_cnt == 6'(FRAME_BITS));
    assign accept    = fend && full_len && (state == IDLE);
    assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
    assign set_valid = (state == WAIT) && ready;
    assign set_tmo   = (state == WAIT) && !ready && tmo_hit;
    assign set_len   = fend && !full_len;
    assign set_ovr   = fend && full_len && (state != IDLE);

    always_comb begin
        status           = '0;
        status[ST_VALID] = valid;
        status[ST_BUSY]  = (state != IDLE);
        status[ST_OVR]   = overrun;
        status[ST_LEN]   = len_err;
        status[ST_TMO]   = tmo;
    end

    // Only a detected cs_n fall arms the receiver; sclk is ignored otherwise.
    // Frame end is evaluated one clk after the synced rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed   <= 1'b0;
            fend    <= 1'b0;
            bit_cnt <= '0;
            rx      <= '0;
            tx      <= '0;
        end else begin
            fend <= cs_rise && armed;
            if (cs_fall) begin
                armed   <= 1'b1;
                bit_cnt <= '0;
                tx      <= {y_reg, status};
            end else if (cs_rise) begin
                armed <= 1'b0;
            end else if (armed) begin
                if (sclk_rise) begin
                    rx <= {rx[FRAME_BITS-2:0], mosi_sync[1]};
                    if (bit_cnt != 6'd33) begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                if (sclk_fall) begin
                    tx <= {tx[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign miso = armed & tx[FRAME_BITS-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x1      <= '0;
            x2      <= '0;
            y_reg   <= '0;
            tmo_cnt <= '0;
            state   <= IDLE;
        end else begin
            state <= state_nxt;
            if (accept) begin
                x1 <= rx[FRAME_BITS-1 -: DW];
                x2 <= rx[DW-1:0];
            end
            if (state == START) begin
                tmo_cnt <= '0;
            end else if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (set_valid) begin
                y_reg <= y;
            end
        end
    end

    // Sticky flags clear when read out at frame start; a coincident set wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
            len_err <= 1'b0;
            tmo     <= 1'b0;
        end else begin
            if (set_valid)    valid   <= 1'b1;
            else if (cs_fall) valid   <= 1'b0;
            if (set_ovr)      overrun <= 1'b1;
            else if (cs_fall) overrun <= 1'b0;
            if (set_len)      len_err <= 1'b1;
            else if (cs_fall) len_err <= 1'b0;
            if (set_tmo)      tmo     <= 1'b1;
            else if (cs_fall) tmo     <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        en        = 1'b0;
        case (state)
            IDLE:  if (accept) state_nxt = START;
            START: begin
                en        = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:  if (ready || tmo_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule
